// File: rtl/ds1302_pkg.sv
`default_nettype none
// ==========================================================================
// ds1302_pkg : call-bit indices, FSM encoding and BCD byte offsets (rev 1.0)
// ==========================================================================
package ds1302_pkg;

  localparam int CALL_RD_SEC = 0;
  localparam int CALL_W_SEC  = 4;
  localparam int CALL_W_MIN  = 5;
  localparam int CALL_W_HOUR = 6;
  localparam int CALL_WP_OFF = 7;

  localparam int SEC_OFS  = 0;
  localparam int MIN_OFS  = 8;
  localparam int HOUR_OFS = 16;

  localparam int TMR_W = 24;

  typedef enum logic [2:0] {
    S_WP_OFF  = 3'd0,
    S_W_HOUR  = 3'd1,
    S_W_MIN   = 3'd2,
    S_W_SEC   = 3'd3,
    S_IDLE    = 3'd4,
    S_RD      = 3'd5,
    S_PUBLISH = 3'd6
  } state_t;

  // Read calls occupy consecutive bits starting at the seconds bit.
  function automatic logic [7:0] call_vec(state_t s, logic [1:0] k);
    logic [7:0] v;
    v = 8'h00;
    case (s)
      S_WP_OFF: v = 8'b1 << CALL_WP_OFF;
      S_W_HOUR: v = 8'b1 << CALL_W_HOUR;
      S_W_MIN:  v = 8'b1 << CALL_W_MIN;
      S_W_SEC:  v = 8'b1 << CALL_W_SEC;
      S_RD:     v = 8'b1 << (CALL_RD_SEC + k);
      default:  v = 8'h00;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ds1302_rtc_poller_if.sv
`default_nettype none
// ==========================================================================
// ds1302_rtc_poller_if : call/done bus towards the DS1302 base module (rev 1.0)
// ==========================================================================
interface ds1302_rtc_poller_if;
  logic [7:0] Call_Sig;
  logic       Done_Sig;
  logic [7:0] WrData;
  logic [7:0] RdData;

  modport master (output Call_Sig, output WrData, input Done_Sig, input RdData);
  modport slave  (input Call_Sig, input WrData, output Done_Sig, output RdData);
endinterface
`default_nettype wire

// File: rtl/ds1302_step_timer.sv
`default_nettype none
// ==========================================================================
// ds1302_step_timer : loadable down-counter with zero flag (rev 1.0)
// ==========================================================================
module ds1302_step_timer #(
  parameter int WIDTH = 24
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic             enable,
  input  wire logic [WIDTH-1:0] load_val,
  output logic                  zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/ds1302_rtc_poller.sv
`default_nettype none
// ==========================================================================
// ds1302_rtc_poller : boots, sets and periodically polls a DS1302 RTC.
// Optional call watchdog via DS1302_TIMEOUT_EN.                  (rev 1.0)
// ==========================================================================
module ds1302_rtc_poller
  import ds1302_pkg::*;
#(
  parameter int          NUM_READ    = 3,
  parameter logic [23:0] POLL_DIV    = 24'd5_000_000,
  parameter logic [23:0] INIT_TIME   = 24'h21_59_50,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4095
) (
  input  wire logic                  CLOCK,
  input  wire logic                  RST_n,
  ds1302_rtc_poller_if.master        bus,
  input  wire logic                  Set_Req,
  input  wire logic [23:0]           Set_Time,
  output logic [8*NUM_READ-1:0]      Time_Out,
  output logic                       Time_Valid,
  output logic                       Busy,
  output logic                       Err
);

  state_t                state, nxt;
  logic [7:0]            call, wr, wr_byte;
  logic [1:0]            rd_idx;
  logic [8*NUM_READ-1:0] shadow;
  logic [23:0]           wtime, set_time_q;
  logic                  pending;
  logic                  active, done_ok, wd_expire, wd_arm, is_call, last_rd;
  logic                  tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0]      tmr_val, wd_load;

  assign active  = |call;
  assign done_ok = active & bus.Done_Sig;
  assign is_call = (state != S_IDLE) && (state != S_PUBLISH);
  assign last_rd = (rd_idx == 2'(NUM_READ - 1));
  assign wd_load = {8'd0, TIMEOUT_CYC} - 24'd1;

`ifdef DS1302_TIMEOUT_EN
  logic err_q;
  assign wd_arm    = is_call & ~active;
  assign wd_expire = active & ~bus.Done_Sig & tmr_zero;
  assign Err       = err_q;
`else
  assign wd_arm    = 1'b0;
  assign wd_expire = 1'b0;
  assign Err       = 1'b0;
`endif

  // One timer serves both purposes: poll interval in IDLE, watchdog in calls.
  assign tmr_load = (state == S_PUBLISH) | wd_arm;
  assign tmr_val  = (state == S_PUBLISH) ? (POLL_DIV - 24'd1) : wd_load;
  assign tmr_en   = (state == S_IDLE) | active;

  ds1302_step_timer #(.WIDTH(TMR_W)) u_timer (
    .clk      (CLOCK),
    .rst_n    (RST_n),
    .load     (tmr_load),
    .enable   (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    wr_byte = 8'h00;
    case (state)
      S_W_HOUR: wr_byte = {1'b0, wtime[HOUR_OFS +: 7]};
      S_W_MIN:  wr_byte = wtime[MIN_OFS +: 8];
      S_W_SEC:  wr_byte = {1'b0, wtime[SEC_OFS +: 7]};
      default:  wr_byte = 8'h00;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      S_WP_OFF: nxt = S_W_HOUR;
      S_W_HOUR: nxt = S_W_MIN;
      S_W_MIN:  nxt = S_W_SEC;
      S_W_SEC:  nxt = S_RD;
      S_RD:     nxt = last_rd ? S_PUBLISH : S_RD;
      default:  nxt = state;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= S_WP_OFF;
      call       <= 8'h00;
      wr         <= 8'h00;
      rd_idx     <= 2'd0;
      shadow     <= '0;
      Time_Out   <= '0;
      Time_Valid <= 1'b0;
      pending    <= 1'b0;
      wtime      <= INIT_TIME;
      set_time_q <= 24'd0;
`ifdef DS1302_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      Time_Valid <= 1'b0;
      if (Set_Req) begin
        pending    <= 1'b1;
        set_time_q <= Set_Time;
      end
      case (state)
        S_IDLE: begin
          // A set request wins over a poll expiry in the same cycle.
          if (pending || Set_Req) begin
            state   <= S_WP_OFF;
            pending <= 1'b0;
            wtime   <= Set_Req ? Set_Time : set_time_q;
          end else if (tmr_zero) begin
            state  <= S_RD;
            rd_idx <= 2'd0;
          end
        end
        S_PUBLISH: begin
          Time_Out   <= shadow;
          Time_Valid <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          if (!active) begin
            call <= call_vec(state, rd_idx);
            wr   <= wr_byte;
          end else if (done_ok || wd_expire) begin
            call  <= 8'h00;
            state <= nxt;
            if (state == S_RD) begin
              shadow[8*rd_idx +: 8] <= done_ok ? bus.RdData : 8'h00;
              rd_idx                <= last_rd ? 2'd0 : rd_idx + 2'd1;
            end
`ifdef DS1302_TIMEOUT_EN
            if (wd_expire) err_q <= 1'b1;
`endif
          end
        end
      endcase
    end
  end

  assign bus.Call_Sig = call;
  assign bus.WrData   = wr;
  assign Busy         = (state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/ds1302_rtc_poller.md
DS1302_RTC_POLLER -- requirements
Module: ds1302_rtc_poller

Interface
REQ-001 SHALL have parameter NUM_READ, default 3, number of time registers read per round (1=sec, 2=sec+min, 3=sec+min+hour).
REQ-002 SHALL have parameter POLL_DIV, default 24'd5_000_000, CLOCK cycles from round end to next round start (minimum 1).
REQ-003 SHALL have parameter INIT_TIME, default 24'h21_59_50, BCD {hour,min,sec} written after reset.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16'd4095, Done watchdog limit, used only when DS1302_TIMEOUT_EN is defined.
REQ-005 SHALL have port CLOCK  input  1  single system clock, rising edge.
REQ-006 SHALL have port RST_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port Call_Sig  output  8  one-hot call vector to the DS1302 base module: bit7 write-protect off, bit6 write hour, bit5 write min, bit4 write sec, bit0/1/2 read sec/min/hour, bit3 always 0.
REQ-008 SHALL have port Done_Sig  input  1  base module completion pulse for the active call.
REQ-009 SHALL have port WrData  output  8  write byte for the active write call.
REQ-010 SHALL have port RdData  input  8  read byte, valid while Done_Sig high on a read call.
REQ-011 SHALL have port Set_Req  input  1  level/pulse request to load Set_Time into the RTC.
REQ-012 SHALL have port Set_Time  input  24  BCD {hour,min,sec}, sampled when Set_Req is accepted.
REQ-013 SHALL have port Time_Out  output  8*NUM_READ  coherent snapshot, sec in [7:0], min in [15:8], hour in [23:16].
REQ-014 SHALL have port Time_Valid  output  1  one-cycle pulse when Time_Out updates.
REQ-015 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port Err  output  1  sticky watchdog flag.

Function
REQ-017 SHALL implement states WP_OFF, W_HOUR, W_MIN, W_SEC, IDLE, RD, PUBLISH; RD iterates index k=0..NUM_READ-1.
REQ-018 SHALL, in each call state, hold exactly one Call_Sig bit high and WrData stable until Done_Sig is sampled high.
REQ-019 SHALL, on the edge Done_Sig is sampled high, clear Call_Sig and advance state; next call asserts the following cycle (one all-zero cycle between calls).
REQ-020 SHALL drive WrData 8'h00 in WP_OFF, hour byte with bit7 forced 0 (24 h mode) in W_HOUR, min byte in W_MIN, sec byte with bit7 forced 0 (clock halt cleared) in W_SEC.
REQ-021 SHALL sequence WP_OFF->W_HOUR->W_MIN->W_SEC->RD(k=0), using INIT_TIME after reset and latched Set_Time after an accepted Set_Req.
REQ-022 SHALL store RdData into shadow byte k on Done_Sig in RD; after k=NUM_READ-1 go to PUBLISH.
REQ-023 SHALL in PUBLISH copy all shadow bytes to Time_Out in one cycle, pulse Time_Valid, go to IDLE and load poll counter with POLL_DIV-1.
REQ-024 SHALL in IDLE decrement the poll counter and enter RD(k=0) the cycle after it reads zero.
REQ-025 SHALL latch Set_Req high in any state into a pending flag; pending is serviced on IDLE entry or in IDLE, priority over poll expiry when both coincide.
REQ-026 SHALL never change Time_Out except in PUBLISH (no partial snapshot during a round or set sequence).
REQ-027 SHALL ignore Done_Sig when no call bit is high.

Reset
REQ-028 SHALL on RST_n low asynchronously set Call_Sig=0, WrData=0, Time_Out=0, Time_Valid=0, Err=0, pending=0, shadow=0, state=WP_OFF, Busy=1.
REQ-029 SHALL on release restart the full boot sequence from WP_OFF, even if reset asserted mid-call.

Configuration
REQ-030 SHALL, with DS1302_TIMEOUT_EN defined, count cycles in each call; at TIMEOUT_CYC without Done_Sig, clear the call, set Err, advance as if done (read byte stored as 8'h00).
REQ-031 SHALL, without DS1302_TIMEOUT_EN, wait indefinitely for Done_Sig and tie Err to 0.

Structure
REQ-032 SHALL place call-bit index constants, state encoding and BCD byte offsets in package ds1302_pkg.
REQ-033 SHALL implement the poll/watchdog down-counter as sub-module ds1302_step_timer (load, enable, zero flag).

Verification
REQ-034 SHALL verify boot: model answers Done after 40 cycles -> Call_Sig order 80,40,20,10,01,02,04; WrData 00,21,59,50; one all-zero cycle between calls.
REQ-035 SHALL verify read: model returns 52,59,21 -> Time_Out=24'h21_59_52 with one Time_Valid pulse; Time_Out unchanged mid-round.
REQ-036 SHALL verify Set_Req pulse with Set_Time=24'h08_30_00 during RD -> round completes, then 80,40,20,10 with WrData 00,08,30,00.
REQ-037 SHALL verify POLL_DIV=10 -> next Call_Sig=01 exactly 11 cycles after Time_Valid; Set_Req on expiry cycle -> 80 issued, not 01.
REQ-038 SHALL verify with DS1302_TIMEOUT_EN, TIMEOUT_CYC=100, model silent on read min -> Err=1 at cycle 100, byte [15:8]=00, sequence continues.
REQ-039 SHALL verify RST_n low during W_MIN -> outputs zero immediately; after release, Call_Sig=80 first.
